// File: rtl/ps2_pkg.sv
// Shared constants, decoder state type and lookup helpers for the PS/2 key display.
package ps2_pkg;

    localparam logic [7:0] BREAK     = 8'hF0;
    localparam logic [7:0] EXT       = 8'hE0;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Entry n is the active-low glyph for hex digit n
    localparam logic [15:0][7:0] HEX_SEG = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    typedef struct packed {
        logic       brk;
        logic       ext;
        logic       held;
        logic       ext_held;
        logic [7:0] code;
    } dec_state_t;

    // Returns {mapped, ascii}; lowercase letters and digits only
    function automatic logic [8:0] ascii_lookup(input logic [7:0] code);
        case (code)
            8'h1C: return {1'b1, 8'h61};
            8'h32: return {1'b1, 8'h62};
            8'h21: return {1'b1, 8'h63};
            8'h23: return {1'b1, 8'h64};
            8'h24: return {1'b1, 8'h65};
            8'h2B: return {1'b1, 8'h66};
            8'h34: return {1'b1, 8'h67};
            8'h33: return {1'b1, 8'h68};
            8'h43: return {1'b1, 8'h69};
            8'h3B: return {1'b1, 8'h6A};
            8'h42: return {1'b1, 8'h6B};
            8'h4B: return {1'b1, 8'h6C};
            8'h3A: return {1'b1, 8'h6D};
            8'h31: return {1'b1, 8'h6E};
            8'h44: return {1'b1, 8'h6F};
            8'h4D: return {1'b1, 8'h70};
            8'h15: return {1'b1, 8'h71};
            8'h2D: return {1'b1, 8'h72};
            8'h1B: return {1'b1, 8'h73};
            8'h2C: return {1'b1, 8'h74};
            8'h3C: return {1'b1, 8'h75};
            8'h2A: return {1'b1, 8'h76};
            8'h1D: return {1'b1, 8'h77};
            8'h22: return {1'b1, 8'h78};
            8'h35: return {1'b1, 8'h79};
            8'h1A: return {1'b1, 8'h7A};
            8'h45: return {1'b1, 8'h30};
            8'h16: return {1'b1, 8'h31};
            8'h1E: return {1'b1, 8'h32};
            8'h26: return {1'b1, 8'h33};
            8'h25: return {1'b1, 8'h34};
            8'h2E: return {1'b1, 8'h35};
            8'h36: return {1'b1, 8'h36};
            8'h3D: return {1'b1, 8'h37};
            8'h3E: return {1'b1, 8'h38};
            8'h46: return {1'b1, 8'h39};
            default: return 9'h000;
        endcase
    endfunction

endpackage

// File: rtl/ps2_key_display_frame_rx.sv
// PS/2 frame receiver: input synchronisers, falling-edge detect, 11-bit shift,
// parity/framing check and partial-frame timeout.
module ps2_frame_rx #(
    parameter int unsigned SYNC_STAGES    = 3,
    parameter int unsigned TIMEOUT_CYCLES = 65536
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] byte_data
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   fall;
    logic [3:0]             bit_cnt;
    logic [10:0]            shift;
    logic [10:0]            shift_next;
    logic [TW-1:0]          idle_cnt;

    assign fall       = clk_prev & ~clk_sync[SYNC_STAGES-1];
    // Bits enter at the top, so after 11 edges shift[0] holds the start bit
    assign shift_next = {data_sync[SYNC_STAGES-1], shift[10:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync   <= '1;
            data_sync  <= '1;
            clk_prev   <= 1'b1;
            bit_cnt    <= '0;
            shift      <= '0;
            idle_cnt   <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
        end else begin
            clk_sync   <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync  <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev   <= clk_sync[SYNC_STAGES-1];
            byte_valid <= 1'b0;
            if (fall) begin
                idle_cnt <= '0;
                shift    <= shift_next;
                if (bit_cnt == 4'd10) begin
                    bit_cnt <= '0;
                    if (!shift_next[0] && shift_next[10] && (^shift_next[9:1])) begin
                        byte_valid <= 1'b1;
                        byte_data  <= shift_next[8:1];
                    end
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (bit_cnt != 4'd0) begin
                if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    bit_cnt  <= '0;
                    idle_cnt <= '0;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end else begin
                idle_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_key_display.sv
// PS/2 make/break decoder with press counter, ASCII lookup, switch priority
// encoder and registered 8-digit 7-segment display.
module ps2_key_display
    import ps2_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 3,
    parameter int unsigned TIMEOUT_CYCLES = 65536
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] sw,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] seg0,
    output logic [7:0] seg1,
    output logic [7:0] seg2,
    output logic [7:0] seg3,
    output logic [7:0] seg4,
    output logic [7:0] seg5,
    output logic [7:0] seg6,
    output logic [7:0] seg7
);

    logic       byte_valid;
    logic [7:0] byte_data;
    dec_state_t dec, dec_next;
    logic [7:0] count, count_next;
    logic [8:0] ascii;
    logic       ascii_shown;
    logic [2:0] enc_idx;
    logic       enc_any;
    logic       unused_sw;

    assign unused_sw = sw[9];

    ps2_frame_rx #(
        .SYNC_STAGES   (SYNC_STAGES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .byte_valid(byte_valid),
        .byte_data (byte_data)
    );

    always_comb begin
        dec_next   = dec;
        count_next = count;
        if (byte_valid) begin
            if (byte_data == EXT) begin
                dec_next.ext = 1'b1;
            end else if (byte_data == BREAK) begin
                dec_next.brk = 1'b1;
            end else if (dec.brk) begin
                if (byte_data == dec.code) dec_next.held = 1'b0;
                dec_next.brk = 1'b0;
                dec_next.ext = 1'b0;
            end else begin
                // Same code while still held is typematic repeat: not a new press
                if (!dec.held || byte_data != dec.code) begin
                    dec_next.code     = byte_data;
                    dec_next.held     = 1'b1;
                    dec_next.ext_held = dec.ext;
                    count_next        = count + 8'd1;
                end
                dec_next.ext = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dec   <= '0;
            count <= '0;
        end else begin
            dec   <= dec_next;
            count <= count_next;
        end
    end

    always_comb begin
        enc_idx = '0;
        enc_any = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (sw[i]) begin
                enc_idx = 3'(i);
                enc_any = 1'b1;
            end
        end
    end

    assign ascii       = ascii_lookup(dec.code);
    assign ascii_shown = dec.held && ascii[8] && !dec.ext_held;

    always_ff @(posedge clk) begin
        if (rst) begin
            seg0 <= SEG_BLANK;
            seg1 <= SEG_BLANK;
            seg2 <= SEG_BLANK;
            seg3 <= SEG_BLANK;
            seg4 <= HEX_SEG[0];
            seg5 <= HEX_SEG[0];
            seg6 <= SEG_BLANK;
            seg7 <= SEG_BLANK;
        end else begin
            seg0 <= dec.held ? HEX_SEG[dec.code[3:0]] : SEG_BLANK;
            seg1 <= dec.held ? HEX_SEG[dec.code[7:4]] : SEG_BLANK;
            seg2 <= ascii_shown ? HEX_SEG[ascii[3:0]] : SEG_BLANK;
            seg3 <= ascii_shown ? HEX_SEG[ascii[7:4]] : SEG_BLANK;
            seg4 <= HEX_SEG[count[3:0]];
            seg5 <= HEX_SEG[count[7:4]];
            seg6 <= (sw[8] && enc_any) ? HEX_SEG[{1'b0, enc_idx}] : SEG_BLANK;
            seg7 <= SEG_BLANK;
        end
    end

endmodule

// File: tb/tb_ps2_key_display.sv
// Scoreboard bench: a behavioural key model predicts all eight digits for every frame.
module tb_ps2_key_display;

    localparam int unsigned SYNC = 3;
    localparam int unsigned TMO  = 100;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] sw;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7;

    always #5 clk = ~clk;

    ps2_key_display #(
        .SYNC_STAGES   (SYNC),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sw      (sw),
        .ps2_clk (ps2_clk),
        .ps2_data(ps2_data),
        .seg0    (seg0),
        .seg1    (seg1),
        .seg2    (seg2),
        .seg3    (seg3),
        .seg4    (seg4),
        .seg5    (seg5),
        .seg6    (seg6),
        .seg7    (seg7)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] exp_q[$];

    logic [7:0] glyph_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                   8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                      8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                      8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                      8'h35, 8'h1A};
    logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                     8'h3E, 8'h46};

    logic       m_held, m_exth, m_brk, m_ext;
    logic [7:0] m_code, m_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] model_segs();
        logic [7:0] s [8];
        logic [7:0] a;
        logic       found;
        for (int i = 0; i < 8; i++) s[i] = 8'hFF;
        found = 1'b0;
        a     = 8'h00;
        for (int i = 0; i < 26; i++)
            if (letter_codes[i] == m_code) begin found = 1'b1; a = 8'h61 + 8'(i); end
        for (int i = 0; i < 10; i++)
            if (digit_codes[i] == m_code) begin found = 1'b1; a = 8'h30 + 8'(i); end
        if (m_held) begin
            s[0] = glyph_tab[m_code[3:0]];
            s[1] = glyph_tab[m_code[7:4]];
            if (found && !m_exth) begin
                s[2] = glyph_tab[a[3:0]];
                s[3] = glyph_tab[a[7:4]];
            end
        end
        s[4] = glyph_tab[m_cnt[3:0]];
        s[5] = glyph_tab[m_cnt[7:4]];
        if (sw[8]) begin
            for (int i = 0; i < 8; i++)
                if (sw[7 - i] && s[6] == 8'hFF) s[6] = glyph_tab[7 - i];
        end
        return {s[7], s[6], s[5], s[4], s[3], s[2], s[1], s[0]};
    endfunction

    task automatic model_reset();
        m_held = 0; m_exth = 0; m_brk = 0; m_ext = 0; m_code = 0; m_cnt = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else if (m_brk) begin
            if (b == m_code) m_held = 0;
            m_brk = 0;
            m_ext = 0;
        end else begin
            if (!(m_held && b == m_code)) begin
                m_code = b; m_held = 1; m_exth = m_ext; m_cnt = m_cnt + 8'd1;
            end
            m_ext = 0;
        end
    endtask

    task automatic pop_compare(input string tag);
        logic [63:0] e;
        check({tag, "_sb_nonempty"}, 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check(tag, {seg7, seg6, seg5, seg4, seg3, seg2, seg1, seg0}, e);
        end
    endtask

    task automatic send_bits(input logic [10:0] frame, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = frame[i];
            tick(2);
            ps2_clk = 1'b0;
            tick(2);
            ps2_clk = 1'b1;
        end
    endtask

    // Display is sampled exactly SYNC+3 cycles after the stop-bit falling edge
    task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic [10:0] frame;
        frame = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        send_bits(frame, 11);
        if (!bad_par && !bad_stop) model_byte(b);
        exp_q.push_back(model_segs());
        tick(SYNC + 1);
        pop_compare("frame");
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        model_reset();
        exp_q.push_back(model_segs());
        tick(1);
        pop_compare("reset");
    endtask

    initial begin
        logic [7:0] code;
        rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; sw = '0;
        tick(3);
        do_reset();
        check("rst_seg0", seg0, 8'hFF);
        check("rst_seg3", seg3, 8'hFF);
        check("rst_seg4", seg4, 8'hC0);
        check("rst_seg5", seg5, 8'hC0);
        check("rst_seg6", seg6, 8'hFF);
        check("rst_seg7", seg7, 8'hFF);

        send_byte(8'h1C, 0, 0);
        check("a_seg0", seg0, 8'hC6);
        check("a_seg1", seg1, 8'hF9);
        check("a_seg2", seg2, 8'hF9);
        check("a_seg3", seg3, 8'h82);
        check("a_seg4", seg4, 8'hF9);
        check("a_seg5", seg5, 8'hC0);
        send_byte(8'hF0, 0, 0);
        send_byte(8'h1C, 0, 0);
        check("rel_seg0", seg0, 8'hFF);
        check("rel_seg2", seg2, 8'hFF);
        check("rel_cnt", seg4, 8'hF9);

        do_reset();
        repeat (3) send_byte(8'h1C, 0, 0);
        check("typematic_cnt", seg4, 8'hF9);
        send_byte(8'hF0, 0, 0);
        send_byte(8'h1C, 0, 0);
        send_byte(8'h32, 0, 0);
        check("b_cnt", seg4, 8'hA4);
        check("b_seg0", seg0, 8'hA4);
        check("b_seg1", seg1, 8'hB0);

        send_byte(8'h45, 1, 0);
        send_byte(8'h45, 0, 1);
        check("bad_seg0", seg0, 8'hA4);
        send_byte(8'h16, 0, 0);
        check("one_seg2", seg2, 8'hF9);
        check("one_seg3", seg3, 8'hB0);

        send_byte(8'hE0, 0, 0);
        send_byte(8'h1C, 0, 0);
        check("ext_seg2", seg2, 8'hFF);
        check("ext_seg0", seg0, 8'hC6);
        send_byte(8'hE0, 0, 0);
        send_byte(8'hF0, 0, 0);
        send_byte(8'h1C, 0, 0);

        send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 10);
        tick(TMO + 10);
        send_byte(8'h1C, 0, 0);
        check("tmo_seg0", seg0, 8'hC6);
        send_byte(8'hF0, 0, 0);
        send_byte(8'h1C, 0, 0);

        send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 10);
        do_reset();
        send_byte(8'h1C, 0, 0);
        check("rstmid_seg0", seg0, 8'hC6);

        sw = 10'h190;
        exp_q.push_back(model_segs());
        tick(2);
        pop_compare("enc_90");
        check("enc_90_seg6", seg6, 8'hF8);
        sw = 10'h100;
        tick(2);
        check("enc_00_seg6", seg6, 8'hFF);
        sw = 10'h090;
        tick(2);
        check("enc_off_seg6", seg6, 8'hFF);
        sw = 10'h105;
        exp_q.push_back(model_segs());
        tick(2);
        pop_compare("enc_05");
        sw = '0;

        do_reset();
        for (int i = 0; i < 256; i++) begin
            code = 8'(i);
            if (code == 8'hF0 || code == 8'hE0) code = 8'h01;
            send_byte(code, 0, 0);
            send_byte(8'hF0, 0, 0);
            send_byte(code, 0, 0);
            if (i == 254) begin
                check("cnt_ff_lo", seg4, 8'h8E);
                check("cnt_ff_hi", seg5, 8'h8E);
            end
        end
        check("wrap_lo", seg4, 8'hC0);
        check("wrap_hi", seg5, 8'hC0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
